uart_16550_rx_deser: RTL and testbench
======================================

Name: uart_16550_rx_deser

Overview:
- Receive deserializer for the 16550 UART core; consumes the serial pin (or internal loopback) and produces characters for the RX FIFO.
- Sits downstream of the uart_rx pin and upstream of the RX FIFO, inside the core behind the PeakRDL regblock.
- Uses 16x oversampling from the shared baud generator and reports per-character parity, framing and break status, plus overrun.

Parameters:
- SYNC_STAGES, 2, number of flops in the uart_rx input synchronizer (≥2).
- OVERSAMPLE, 16, baud_tick strobes per bit. Fixed at 16 for 16550 compatibility; the counter width is derived from it.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- baud_tick  input  1  16x-baud strobe, one clk wide.
- rx_enable  input  1  receiver enable; 0 forces IDLE.
- cfg_wls  input  2  word length select: 0=5, 1=6, 2=7, 3=8 bits.
- cfg_pen  input  1  parity enable.
- cfg_eps  input  1  even parity select.
- cfg_stick  input  1  stick parity.
- loopback_en  input  1  1 selects loopback_tx instead of uart_rx.
- loopback_tx  input  1  internal TX serial line.
- uart_rx  input  1  asynchronous serial input pin.
- rx_fifo_full  input  1  RX FIFO full.
- rx_push  output  1  one-cycle character push.
- rx_data  output  8  received character, LSB-aligned, unused upper bits 0.
- rx_pe  output  1  parity error for rx_data.
- rx_fe  output  1  framing error for rx_data.
- rx_bi  output  1  break indication for rx_data.
- rx_overrun  output  1  one-cycle pulse: a character was dropped because the FIFO was full.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - Synchronizer flops reset to 1 (mark).
  - State = IDLE, all counters = 0.
  - rx_push, rx_data, rx_pe, rx_fe, rx_bi, rx_overrun, rx_busy = 0.
- Line source: mux(loopback_en, loopback_tx, uart_rx) feeds the SYNC_STAGES synchronizer. The result is rxs.
- State advance: all state changes occur only on cycles with baud_tick=1. The 4-bit counter tcnt increments per tick.
- IDLE:
  - On a tick with rxs=0 and rx_enable=1: go to START, tcnt=0.
  - At the same time, latch cfg_wls/pen/eps/stick into frame registers. Config changes mid-frame take effect next frame.
- START:
  - At tcnt==7 (8th tick, mid start bit), sample rxs.
  - rxs=1 → false start, return to IDLE, no push.
  - rxs=0 → go to DATA, tcnt=0, bit index=0.
- DATA:
  - At tcnt==15, sample rxs into shift bit[idx], LSB first.
  - After 5+wls bits: go to PARITY if pen, else STOP.
- PARITY:
  - At tcnt==15, sample the parity bit.
  - Expected parity bit:
    - stick=0: even → XOR of data; odd → inverted XOR of data.
    - stick=1: eps=1 → 0; eps=0 → 1.
  - pe = sampled ≠ expected.
- STOP:
  - At tcnt==15, sample the first stop bit only.
  - fe = (stop==0).
  - bi = data all 0 AND parity bit 0 (if enabled) AND stop 0.
  - Next cycle: if rx_fifo_full=0, rx_push=1 with rx_data/pe/fe/bi. Otherwise rx_overrun=1 and no push.
  - Status outputs hold until the next push.
  - bi=1 → go to BREAK. Otherwise → IDLE, so a start bit immediately after a mid-stop sample is detected.
- BREAK: wait for a tick with rxs=1, then IDLE. A break yields exactly one zero character.
- rx_enable=0 in any state: next clk goes to IDLE, no push; an in-progress frame is discarded.
- Push latency: rx_push asserts the clk cycle after the baud_tick cycle on which the stop bit is sampled.
- Simultaneous push and FIFO going non-full in the same cycle: the decision uses rx_fifo_full as seen in the push cycle.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous).

Decomposition:
- uart_16550_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - WLS_5..WLS_8 encodings.
  - Function expected_parity(data, wls, eps, stick).
- Synchronizer: the common glitch-free synchronizer is instantiated; no new sub-module.
- The FSM, counters and shift register all live in this module.

Test Plan:
- 8N1 (wls=3, pen=0), baud_tick every cycle, send 0xA5:
  - rx_push on the 152nd tick after the first low-sampled tick.
  - rx_data=0xA5; pe=fe=bi=0.
- 7E1 (wls=2, pen=1, eps=1), send 0x35 with a wrong parity bit 1 → rx_data=0x35, rx_pe=1.
- 0x00 with stop=0 (8N1), line held low 400 ticks:
  - Exactly one push: data=0x00, fe=1, bi=1.
  - rx_busy stays high until rxs=1, then no further pushes.
- 4-tick low glitch on an idle line → START aborts at tcnt==7; no push; rx_busy returns to 0.
- rx_fifo_full=1 during the stop sample of 0x5A → rx_overrun pulses 1 cycle, rx_push stays 0. The next frame 0x3C with full=0 pushes normally.
- loopback_en=1 with 5O2 config (wls=0, pen=1, eps=0), loopback_tx sends 0x1F with parity 0:
  - rx_data=0x1F, pe=0; uart_rx is ignored.
  - Asserting rst_n=0 mid-DATA clears all outputs immediately.

Source files
------------

// File: rtl/uart_16550_pkg.sv
// Shared definitions for the 16550 UART core receive path.
//   rx_state_t      : receive deserializer FSM states
//   WLS_5..WLS_8    : word length select encodings (LCR[1:0])
//   expected_parity : parity bit a well-formed frame must carry
package uart_16550_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  // Stick parity forces the bit to ~eps; otherwise even parity carries the
  // XOR of the data bits and odd parity carries its inverse.
  function automatic logic expected_parity(
    input logic [7:0] data,
    input logic [1:0] wls,
    input logic       eps,
    input logic       stick
  );
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - wls);
    if (stick) return ~eps;
    if (eps) return ^(data & mask);
    return ~(^(data & mask));
  endfunction

endpackage

// File: rtl/uart_16550_rx_deser.sv
// Receive deserializer of the 16550 UART core.
// Samples the (optionally looped-back) serial line at 16x oversampling,
// assembles 5..8 bit characters with optional parity, and hands each one to
// the RX FIFO together with parity / framing / break status.
// Ports:
//   clk, rst_n          : core clock, asynchronous active-low reset
//   baud_tick           : 16x baud strobe, one clk wide
//   rx_enable           : receiver enable, 0 forces IDLE and drops the frame
//   cfg_wls/pen/eps/stick : line control, latched at each start bit
//   loopback_en/tx      : internal loopback source select and line
//   uart_rx             : asynchronous serial pin
//   rx_fifo_full        : RX FIFO full
//   rx_push, rx_data, rx_pe, rx_fe, rx_bi : character push and its status
//   rx_overrun          : one-cycle pulse when a character is dropped
//   rx_busy             : FSM is not IDLE
// Handshake: rx_push is a one-cycle strobe with no back-pressure; when the
// FIFO reports full in that cycle the character is dropped and rx_overrun
// pulses instead. rx_data/pe/fe/bi are valid while rx_push is high and hold
// that value until the next push.
module uart_16550_rx_deser
  import uart_16550_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       rx_enable,
  input  logic [1:0] cfg_wls,
  input  logic       cfg_pen,
  input  logic       cfg_eps,
  input  logic       cfg_stick,
  input  logic       loopback_en,
  input  logic       loopback_tx,
  input  logic       uart_rx,
  input  logic       rx_fifo_full,
  output logic       rx_push,
  output logic [7:0] rx_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] END_CNT = CW'(OVERSAMPLE - 1);

  // Line select and synchronizer; flops idle at mark so reset never looks
  // like a start bit.
  logic                   line;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  assign line = loopback_en ? loopback_tx : uart_rx;
  assign rxs  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], line};
  end

  rx_state_t     state;
  logic [CW-1:0] tcnt;
  logic [2:0]    idx;
  logic [2:0]    last_idx;
  logic [7:0]    shift;
  logic [1:0]    f_wls;
  logic          f_pen, f_eps, f_stick;
  logic          par_q, pe_q, done_q;
  logic [7:0]    frm_data;
  logic          frm_pe, frm_fe, frm_bi;
  logic [7:0]    hold_data;
  logic          hold_pe, hold_fe, hold_bi;
  logic          tcnt_end;
  logic          stop_brk;

  assign tcnt_end = (tcnt == END_CNT);

  // Break: every sampled bit of the frame was space, including the stop bit.
  assign stop_brk = (shift == 8'h00) & ~par_q & ~rxs;

  always_comb begin
    last_idx = 3'd7;
    unique case (f_wls)
      WLS_5: last_idx = 3'd4;
      WLS_6: last_idx = 3'd5;
      WLS_7: last_idx = 3'd6;
      WLS_8: last_idx = 3'd7;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcnt     <= '0;
      idx      <= '0;
      shift    <= '0;
      f_wls    <= '0;
      f_pen    <= 1'b0;
      f_eps    <= 1'b0;
      f_stick  <= 1'b0;
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
      done_q   <= 1'b0;
      frm_data <= '0;
      frm_pe   <= 1'b0;
      frm_fe   <= 1'b0;
      frm_bi   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!rx_enable) begin
        state <= IDLE;
        tcnt  <= '0;
      end else if (baud_tick) begin
        unique case (state)
          IDLE: begin
            if (!rxs) begin
              state   <= START;
              tcnt    <= '0;
              f_wls   <= cfg_wls;
              f_pen   <= cfg_pen;
              f_eps   <= cfg_eps;
              f_stick <= cfg_stick;
            end
          end
          START: begin
            if (tcnt == MID_CNT) begin
              // From here on tcnt==END_CNT lands in the middle of each bit.
              if (rxs) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                tcnt  <= '0;
                idx   <= '0;
                shift <= '0;
                par_q <= 1'b0;
                pe_q  <= 1'b0;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DATA: begin
            tcnt <= tcnt_end ? '0 : tcnt + 1'b1;
            if (tcnt_end) begin
              shift[idx] <= rxs;
              if (idx == last_idx) state <= f_pen ? PARITY : STOP;
              else                 idx   <= idx + 1'b1;
            end
          end
          PARITY: begin
            tcnt <= tcnt_end ? '0 : tcnt + 1'b1;
            if (tcnt_end) begin
              par_q <= rxs;
              pe_q  <= rxs ^ expected_parity(shift, f_wls, f_eps, f_stick);
              state <= STOP;
            end
          end
          STOP: begin
            tcnt <= tcnt_end ? '0 : tcnt + 1'b1;
            if (tcnt_end) begin
              frm_data <= shift;
              frm_pe   <= pe_q;
              frm_fe   <= ~rxs;
              frm_bi   <= stop_brk;
              done_q   <= 1'b1;
              // Returning to IDLE at mid-stop lets a start bit that follows
              // immediately be caught.
              state    <= stop_brk ? BREAK : IDLE;
            end
          end
          BREAK: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The full/overrun decision uses rx_fifo_full as seen in the push cycle.
  assign rx_push    = done_q & ~rx_fifo_full;
  assign rx_overrun = done_q & rx_fifo_full;
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_pe   <= 1'b0;
      hold_fe   <= 1'b0;
      hold_bi   <= 1'b0;
    end else if (rx_push) begin
      hold_data <= frm_data;
      hold_pe   <= frm_pe;
      hold_fe   <= frm_fe;
      hold_bi   <= frm_bi;
    end
  end

  // Status follows the new character during the push cycle, then holds.
  assign rx_data = rx_push ? frm_data : hold_data;
  assign rx_pe   = rx_push ? frm_pe   : hold_pe;
  assign rx_fe   = rx_push ? frm_fe   : hold_fe;
  assign rx_bi   = rx_push ? frm_bi   : hold_bi;

endmodule

// File: tb/tb_uart_16550_rx_deser.sv
// Bench for uart_16550_rx_deser: directed frames for latency, parity, break,
// glitch, overrun, disable, loopback and reset, then randomized frames.
// Expected characters come from a serial-line model and are queued when the
// frame is sent; a monitor pops and compares on every push/overrun.
module tb_uart_16550_rx_deser;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_enable = 1'b0;
  logic [1:0] cfg_wls = 2'd3;
  logic       cfg_pen = 1'b0;
  logic       cfg_eps = 1'b0;
  logic       cfg_stick = 1'b0;
  logic       loopback_en = 1'b0;
  logic       loopback_tx = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_fifo_full = 1'b0;
  logic       rx_push;
  logic [7:0] rx_data;
  logic       rx_pe, rx_fe, rx_bi, rx_overrun, rx_busy;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int push_cnt = 0;
  int tick_div = 1;
  int tick_cnt = 0;
  logic [11:0] exp_q[$];  // {overrun, data, pe, fe, bi}

  uart_16550_rx_deser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .rx_enable    (rx_enable),
    .cfg_wls      (cfg_wls),
    .cfg_pen      (cfg_pen),
    .cfg_eps      (cfg_eps),
    .cfg_stick    (cfg_stick),
    .loopback_en  (loopback_en),
    .loopback_tx  (loopback_tx),
    .uart_rx      (uart_rx),
    .rx_fifo_full (rx_fifo_full),
    .rx_push      (rx_push),
    .rx_data      (rx_data),
    .rx_pe        (rx_pe),
    .rx_fe        (rx_fe),
    .rx_bi        (rx_bi),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Baud strobe: one clk wide every tick_div cycles, changed on negedge.
  always @(negedge clk) begin
    baud_tick = (tick_cnt == 0);
    tick_cnt  = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks and reference model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait n baud ticks, then return on a negedge so inputs change away from posedge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    if (loopback_en) loopback_tx = v;
    else             uart_rx = v;
    wait_ticks(n);
  endtask

  function automatic logic ref_parity(input logic [7:0] d, input int nbits,
                                      input logic eps, input logic stick);
    logic [7:0] m;
    int ones;
    m = 8'((1 << nbits) - 1);
    ones = $countones(d & m);
    if (stick) return !eps;
    return eps ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  function automatic logic [11:0] make_exp(input logic [7:0] d, input int nbits,
                                           input logic pen, input logic eps, input logic stick,
                                           input logic par_bit, input logic stop_bit,
                                           input logic ovr);
    logic [7:0] dm;
    logic pe, fe, bi;
    if (ovr) return 12'h800;
    dm = d & 8'((1 << nbits) - 1);
    pe = pen && (par_bit != ref_parity(d, nbits, eps, stick));
    fe = !stop_bit;
    bi = (dm == 8'h00) && (!pen || !par_bit) && !stop_bit;
    return {1'b0, dm, pe, fe, bi};
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nbits,
                            input logic pen, input logic eps, input logic stick,
                            input logic par_bit, input logic stop_bit, input int nstop,
                            input logic full_stop, input logic expect_char);
    cfg_wls = 2'(nbits - 5);
    cfg_pen = pen;
    cfg_eps = eps;
    cfg_stick = stick;
    if (expect_char)
      exp_q.push_back(make_exp(d, nbits, pen, eps, stick, par_bit, stop_bit, full_stop));
    drive_bit(1'b0, 8);
    // Config is latched at the start bit; scrambling it now must not matter.
    {cfg_wls, cfg_pen, cfg_eps, cfg_stick} = 5'($urandom);
    drive_bit(1'b0, 8);
    for (int k = 0; k < nbits; k++) drive_bit(d[k], 16);
    if (pen) drive_bit(par_bit, 16);
    rx_fifo_full = full_stop;
    drive_bit(stop_bit, 16);
    rx_fifo_full = 1'b0;
    if (nstop == 2) drive_bit(1'b1, 16);
    if (loopback_en) loopback_tx = 1'b1;
    else             uart_rx = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [11:0] act;
    #1;
    if (rst_n && (rx_push || rx_overrun)) begin
      act = rx_overrun ? 12'h800 : {1'b0, rx_data, rx_pe, rx_fe, rx_bi};
      if (rx_push) push_cnt++;
      check("push_ovr_excl", 32'(rx_push & rx_overrun), 32'd0);
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_char: got %03h expected none", act);
      end else begin
        check("sb_char", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_push", 32'(rx_push), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_status", 32'({rx_pe, rx_fe, rx_bi}), 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    check("rst_busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    rx_enable = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5, tick every cycle: push 2 sync + 1 + 152 ticks after the fall.
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1);
      begin
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < 400 && !seen) begin
          @(posedge clk);
          n++;
          #1;
          seen = rx_push;
        end
        check("push_latency", 32'(n), 32'd155);
      end
    join
    wait_ticks(4);

    // 7E1 0x35 with wrong parity bit.
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    wait_ticks(4);

    // Break: line low for 400 ticks gives exactly one zero character.
    cfg_wls = 2'd3; cfg_pen = 1'b0; cfg_eps = 1'b0; cfg_stick = 1'b0;
    base = push_cnt;
    exp_q.push_back(make_exp(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    uart_rx = 1'b0;
    wait_ticks(300);
    check("break_busy", 32'(rx_busy), 1);
    wait_ticks(100);
    uart_rx = 1'b1;
    wait_ticks(4);
    check("break_idle", 32'(rx_busy), 0);
    check("break_pushes", 32'(push_cnt - base), 1);

    // 4-tick glitch aborts at mid start bit.
    base = push_cnt;
    uart_rx = 1'b0;
    wait_ticks(4);
    uart_rx = 1'b1;
    wait_ticks(3);
    check("glitch_busy", 32'(rx_busy), 1);
    wait_ticks(10);
    check("glitch_idle", 32'(rx_busy), 0);
    check("glitch_pushes", 32'(push_cnt - base), 0);

    // Overrun on 0x5A, then 0x3C pushes normally.
    base = push_cnt;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    wait_ticks(4);
    check("overrun_no_push", 32'(push_cnt - base), 0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    wait_ticks(4);

    // Disabling mid-frame discards it.
    base = push_cnt;
    fork
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      begin
        wait_ticks(60);
        rx_enable = 1'b0;
        wait_ticks(2);
        check("disable_busy", 32'(rx_busy), 0);
      end
    join
    rx_enable = 1'b1;
    wait_ticks(20);
    check("disable_pushes", 32'(push_cnt - base), 0);

    // Loopback 5O2 0x1F, uart_rx held low and ignored.
    loopback_tx = 1'b1;
    loopback_en = 1'b1;
    uart_rx = 1'b0;
    wait_ticks(4);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    wait_ticks(4);
    check("hold_data", 32'(rx_data), 32'h1F);

    // Reset mid-DATA clears outputs asynchronously.
    loopback_tx = 1'b0;
    wait_ticks(16);
    loopback_tx = 1'b1;
    wait_ticks(24);
    check("mid_busy", 32'(rx_busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(rx_busy), 0);
    check("async_rst_data", 32'(rx_data), 0);
    check("async_rst_push", 32'(rx_push), 0);
    @(negedge clk);
    loopback_en = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // Randomized frames.
    for (int i = 0; i < 25; i++) begin
      logic [7:0] d;
      int nbits, nstop;
      logic pen, eps, stick, par, stop, full;
      tick_div = $urandom_range(1, 3);
      nbits = $urandom_range(5, 8);
      d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pen = 1'($urandom_range(0, 1));
      eps = 1'($urandom_range(0, 1));
      stick = 1'($urandom_range(0, 1));
      par = ref_parity(d, nbits, eps, stick) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      nstop = $urandom_range(1, 2);
      full = ($urandom_range(0, 7) == 0);
      send_frame(d, nbits, pen, eps, stick, par, stop, nstop, full, 1'b1);
      // After a low stop bit the receiver re-arms on the still-low line, so
      // leave enough mark time for that false start to abort.
      wait_ticks(stop ? $urandom_range(0, 12) : 24 + $urandom_range(0, 8));
    end

    wait_ticks(40);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
